// File: rtl/int_to_ascii_fmt.sv
// ---------------------------------------------------------------------------
// int_to_ascii_fmt
//
// Purpose: converts one DATA_W-bit integer per transaction to decimal ASCII
// and streams the characters out one byte per handshake. The conversion is
// an iterative double-dabble (binary to BCD) engine that does one bit per
// clock. Leading zeros are suppressed, and a leading '-' is emitted for
// negative signed input.
//
// Parameters:
//   DATA_W  input integer width (8..64)
//   SIGNED  1 = two's complement input, 0 = unsigned input
//
// Optional feature (compile-time macro ITOA_NEWLINE_EN):
//   When defined, a line feed (8'h0A) follows the last digit and carries
//   out_last_o.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   input integer valid
//   in_ready_o   block can accept a new integer (IDLE only)
//   in_data_i    integer to format
//   out_valid_o  out_char_o holds a valid character
//   out_ready_i  sink accepts the character
//   out_char_o   ASCII character
//   out_last_o   final character of the current number
//   busy_o       high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module int_to_ascii_fmt #(
    parameter int DATA_W = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        out_char_o,
    output logic              out_last_o,
    output logic              busy_o
);

    // ceil(DATA_W * log10(2)) in integer arithmetic.
    localparam int NDIG = (DATA_W * 30103 + 99999) / 100000;
    localparam int BW   = 4 * NDIG;
    localparam int CW   = $clog2(DATA_W);
    localparam int IW   = $clog2(NDIG);

`ifdef ITOA_NEWLINE_EN
    localparam bit NL_EN = 1'b1;
`else
    localparam bit NL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bcd_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic              sign_q;   // '-' still to be emitted
    logic              dig_q;    // digits still to be emitted
    logic              nl_q;     // line feed still to be emitted
    logic              out_valid_q;
    logic [7:0]        out_char_q;
    logic              out_last_q;

    logic              in_fire;
    logic              out_fire;
    logic              neg;
    logic [DATA_W-1:0] magnitude;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_step;
    logic [IW-1:0]     msd_idx;
    logic [IW-1:0]     cur_idx;
    logic [3:0]        cur_nib;
    logic [7:0]        nxt_char;
    logic              nxt_last;
    logic              load_en;

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign out_char_o  = out_char_q;
    assign out_last_o  = out_last_q;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_q && out_ready_i;

    // Negating the most-negative value wraps to 2^(DATA_W-1), which is
    // exactly the right magnitude when read as unsigned.
    assign neg       = SIGNED && in_data_i[DATA_W-1];
    assign magnitude = neg ? (~in_data_i + DATA_W'(1)) : in_data_i;

    // One double-dabble step: correct every nibble >= 5, then shift in the
    // next binary bit.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = (bcd_adj << 1) | BW'(shift_q[DATA_W-1]);
    end

    // Index of the most significant non-zero digit (0 when the value is 0).
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd_idx = IW'(i);
            end
        end
    end

    // Before the first character is loaded the digit pointer comes from the
    // leading-zero search; afterwards it comes from idx_q.
    always_comb begin
        cur_idx  = out_valid_q ? idx_q : msd_idx;
        cur_nib  = bcd_q[{cur_idx, 2'b00} +: 4];
        nxt_char = 8'h0A;
        nxt_last = 1'b1;
        if (sign_q) begin
            nxt_char = 8'h2D;
            nxt_last = 1'b0;
        end else if (dig_q) begin
            nxt_char = {4'h3, cur_nib};
            nxt_last = (cur_idx == '0) && !NL_EN;
        end
    end

    // Load a new character on entry to EMIT, or when the current non-final
    // character is accepted; otherwise the output is held through stalls.
    assign load_en = (state_q == EMIT) && (!out_valid_q || (out_ready_i && !out_last_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_fire) state_d = CONV;
            CONV: if (cnt_q == CW'(DATA_W - 1)) state_d = EMIT;
            EMIT: if (out_fire && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            sign_q      <= 1'b0;
            dig_q       <= 1'b0;
            nl_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        shift_q <= magnitude;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        sign_q  <= neg;
                        dig_q   <= 1'b1;
                        nl_q    <= NL_EN;
                    end
                end
                CONV: begin
                    bcd_q   <= bcd_step;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + CW'(1);
                end
                EMIT: begin
                    if (load_en) begin
                        out_valid_q <= 1'b1;
                        out_char_q  <= nxt_char;
                        out_last_q  <= nxt_last;
                        if (sign_q) begin
                            sign_q <= 1'b0;
                            idx_q  <= cur_idx;
                        end else if (dig_q) begin
                            if (cur_idx == '0) dig_q <= 1'b0;
                            else               idx_q <= cur_idx - IW'(1);
                        end else begin
                            nl_q <= 1'b0;
                        end
                    end else if (out_fire && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_ascii_fmt.sv
// ---------------------------------------------------------------------------
// tb_int_to_ascii_fmt
//
// Directed bench for int_to_ascii_fmt (DATA_W=32). Instance dut_s is signed,
// dut_u is unsigned; they share clock, reset, data and out_ready, and the
// outputs of the instance under test are selected by sel_u.
// Expected strings account for ITOA_NEWLINE_EN when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_int_to_ascii_fmt;

`ifdef ITOA_NEWLINE_EN
    localparam bit NL = 1'b1;
`else
    localparam bit NL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_s, in_valid_u;
    logic [31:0] in_data;
    logic        out_ready;

    logic       ready_s, valid_s, last_s, busy_s;
    logic [7:0] char_s;
    logic       ready_u, valid_u, last_u, busy_u;
    logic [7:0] char_u;

    logic       sel_u;
    logic       cur_ready, cur_valid, cur_last, cur_busy;
    logic [7:0] cur_char;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_to_ascii_fmt #(.DATA_W(32), .SIGNED(1'b1)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid_s), .in_ready_o(ready_s), .in_data_i(in_data),
        .out_valid_o(valid_s), .out_ready_i(out_ready), .out_char_o(char_s),
        .out_last_o(last_s), .busy_o(busy_s)
    );

    int_to_ascii_fmt #(.DATA_W(32), .SIGNED(1'b0)) dut_u (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid_u), .in_ready_o(ready_u), .in_data_i(in_data),
        .out_valid_o(valid_u), .out_ready_i(out_ready), .out_char_o(char_u),
        .out_last_o(last_u), .busy_o(busy_u)
    );

    always_comb begin
        cur_ready = sel_u ? ready_u : ready_s;
        cur_valid = sel_u ? valid_u : valid_s;
        cur_char  = sel_u ? char_u  : char_s;
        cur_last  = sel_u ? last_u  : last_s;
        cur_busy  = sel_u ? busy_u  : busy_s;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one integer to the selected instance; returns at the falling
    // edge right after the accepting rising edge.
    task automatic send(input bit to_u, input logic [31:0] d);
        @(negedge clk);
        sel_u   = to_u;
        in_data = d;
        check("in_ready_before_send", {31'd0, cur_ready}, 32'd1);
        if (to_u) in_valid_u = 1'b1;
        else      in_valid_s = 1'b1;
        @(negedge clk);
        in_valid_s = 1'b0;
        in_valid_u = 1'b0;
    endtask

    // Collect one formatted number. mode 0: out_ready always 1 (also checks
    // back-to-back characters); mode 1: out_ready pattern 1,0,0 repeating.
    task automatic recv(input string tag, input string digits, input int mode, input bit chk_lat);
        string full;
        int    k;
        int    cyc;
        int    first;
        full  = digits;
        if (NL) full = {digits, "\n"};
        k     = 0;
        cyc   = 0;
        first = -1;
        while (k < full.len() && cyc < 300) begin
            @(negedge clk);
            cyc++;
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
            if (cur_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (chk_lat) check({tag, "_latency"}, first, 33);
                end
                check({tag, "_char"}, {24'd0, cur_char}, {24'd0, full[k]});
                if (out_ready) begin
                    check({tag, "_last"}, {31'd0, cur_last}, {31'd0, (k == full.len() - 1)});
                    if (mode == 0) check({tag, "_gap"}, cyc, first + k);
                    k++;
                end
            end
        end
        check({tag, "_count"}, k, full.len());
        @(negedge clk);
        out_ready = 1'b1;
        check({tag, "_idle_valid"}, {31'd0, cur_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, cur_ready}, 32'd1);
        check({tag, "_idle_busy"},  {31'd0, cur_busy},  32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        in_valid_s = 1'b0;
        in_valid_u = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        sel_u      = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'd0, cur_ready}, 32'd1);
        check("rst_out_valid", {31'd0, cur_valid}, 32'd0);
        check("rst_out_char",  {24'd0, cur_char},  32'd0);
        check("rst_out_last",  {31'd0, cur_last},  32'd0);
        check("rst_busy",      {31'd0, cur_busy},  32'd0);
        rst = 1'b0;

        // Zero: single '0' after DATA_W+1 cycles.
        send(1'b0, 32'd0);
        check("zero_busy", {31'd0, cur_busy}, 32'd1);
        recv("zero", "0", 0, 1'b1);

        send(1'b0, 32'hFFFF_FFD6);             // -42
        recv("neg42", "-42", 0, 1'b1);

        send(1'b0, 32'h8000_0000);             // most negative
        recv("minint", "-2147483648", 0, 1'b1);

        send(1'b0, 32'd12345678);              // with output stalls
        recv("stall", "12345678", 1, 1'b0);

        send(1'b1, 32'hFFFF_FFFF);             // unsigned max, no sign
        recv("umax", "4294967295", 0, 1'b1);

        send(1'b0, 32'hFFFF_FFFF);             // -1 on the signed instance
        recv("neg1", "-1", 0, 1'b1);

        // Reset in the middle of "-100".
        send(1'b0, 32'hFFFF_FF9C);
        n = 0;
        while (!cur_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_first_valid", {31'd0, cur_valid}, 32'd1);
        check("abort_char_minus", {24'd0, cur_char}, 32'h2D);
        @(negedge clk);
        check("abort_char_one", {24'd0, cur_char}, 32'h31);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", {31'd0, cur_valid}, 32'd0);
        check("abort_ready", {31'd0, cur_ready}, 32'd1);
        check("abort_busy",  {31'd0, cur_busy},  32'd0);
        check("abort_char",  {24'd0, cur_char},  32'd0);
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("abort_quiet", {31'd0, cur_valid}, 32'd0);
        end
        send(1'b0, 32'd7);
        recv("seven", "7", 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_to_ascii_fmt.md
Name: int_to_ascii_fmt

Overview:
- Sequential integer-to-decimal-ASCII formatter; hardware equivalent of the `%0d` display path.
- Accepts one DATA_W-bit integer (signed or unsigned) per transaction.
- Converts it with an iterative double-dabble (binary→BCD) engine.
- Streams the decimal characters out one byte per handshake. Sits downstream of typed datapaths (byte/shortint/int/longint producers) and feeds a UART/console character sink.

Parameters:
- DATA_W, 32, input integer width; legal 8..64.
- SIGNED, 1, 1 = input is two's complement (byte/int semantics); 0 = unsigned.
- NDIG, derived localparam = ceil(DATA_W*log10(2)), BCD digit count (32→10, 64→20, 8→3).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input integer valid.
- in_ready_o  out  1  block can accept a new integer.
- in_data_i  in  DATA_W  integer to format.
- out_valid_o  out  1  out_char_o holds a valid character.
- out_ready_i  in  1  sink accepts the character.
- out_char_o  out  8  ASCII character.
- out_last_o  out  1  final character of current number.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: in_ready_o=1, out_valid_o=0, out_char_o=8'h00, out_last_o=0, busy_o=0, state=IDLE, BCD/shift registers cleared.
- Reset has priority over every other event; reset mid-CONV or mid-EMIT aborts the number immediately, emits no further characters, and returns to IDLE.
- Input handshake: transfer when in_valid_i && in_ready_o. in_ready_o=1 only in IDLE.
- Output handshake: transfer when out_valid_o && out_ready_i. While out_valid_o=1 and out_ready_i=0, out_char_o and out_last_o are held stable.
- FSM IDLE:
  - On input transfer, latch neg = SIGNED && in_data_i[DATA_W-1].
  - Latch magnitude = neg ? (~in_data_i + 1) : in_data_i, treated as unsigned DATA_W bits. The most-negative value therefore yields 2^(DATA_W-1), which is correct.
  - Go to CONV.
- FSM CONV:
  - Exactly DATA_W cycles of double-dabble: add 3 to each BCD nibble ≥5, then shift left by 1 bit.
  - Then go to EMIT; first character valid on the next cycle.
  - out_valid_o first asserts DATA_W+1 cycles after the accepting edge.
- FSM EMIT, character order:
  - '-' (8'h2D) first, if neg.
  - Then digits from the most significant non-zero BCD nibble down to digit 0, each as 8'h30 + nibble.
  - Leading zeros suppressed; value 0 emits the single character '0'.
- out_last_o=1 only with the final character. Its handshake returns the FSM to IDLE; in_ready_o=1 on the following cycle.
- No pipelining: one number in flight; at most NDIG+1 characters (+1 with the optional feature).
- in_valid_i during CONV/EMIT is ignored and not consumed (in_ready_o=0).

Optional Feature:
- Macro: ITOA_NEWLINE_EN.
- Defined: after the final digit, an extra character 8'h0A (line feed) is emitted. out_last_o moves to the LF; the digit before it has out_last_o=0.
- Undefined: no terminator; out_last_o accompanies the final digit. Behaviour is otherwise identical.

Test Plan (DATA_W=32, SIGNED=1, out_ready_i=1, macro undefined unless stated):
- Reset release, in_data_i=0 → after 33 cycles a single '0' (8'h30) with out_last_o=1; in_ready_o=1 on the next cycle.
- in_data_i=-42 → '-','4','2' on three consecutive cycles; out_last_o only on '2'; busy_o low afterwards.
- in_data_i=32'h80000000 → "-2147483648", 11 characters, no overflow.
- in_data_i=12345678 with out_ready_i toggling 1,0,0,1,... → "12345678" in order; out_char_o stable through each stall; no drop or duplicate.
- SIGNED=0, in_data_i=32'hFFFFFFFF → "4294967295" with no '-'. With ITOA_NEWLINE_EN defined, same input → 10 digits then 8'h0A carrying out_last_o.
- in_data_i=-100, rst_i asserted for 1 cycle after '-' and '1' are emitted → no further output; out_valid_o=0 and in_ready_o=1 the cycle after reset; next input 7 → '7' only.
